// File: rtl/float_pkg.sv
// Shared single-precision float types for the float-to-int converter and the float adder.
package float_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MAN_W    = 23;
  localparam int EXP_W    = 8;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float_t;

  // Adder working format: hidden one, mantissa, then guard/round/sticky.
  localparam int FADD_SIG_W = MAN_W + 4;

  typedef struct packed {
    logic                  sign;
    logic [EXP_W-1:0]      exp;
    logic [FADD_SIG_W-1:0] sig;
  } fadd_unpacked_t;

  typedef enum logic [1:0] {
    FADD_IDLE,
    FADD_ALIGN,
    FADD_NORM,
    FADD_ROUND
  } fadd_stage_e;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NAN,
    CLS_SAT,
    CLS_NORM
  } f2i_class_e;

  function automatic logic isZeroOrDenorm(float_t f);
    return f.exp == '0;
  endfunction

  function automatic logic isNan(float_t f);
    return (f.exp == EXP_W'(EXP_MAX)) && (f.man != '0);
  endfunction

  function automatic logic isInf(float_t f);
    return (f.exp == EXP_W'(EXP_MAX)) && (f.man == '0);
  endfunction

endpackage

// File: rtl/float_rshift_sticky.sv
// Combinational right shifter that also reports the first bit shifted out (guard)
// and the OR of every bit below it (sticky).
module float_rshift_sticky #(
  parameter int W    = 16,
  parameter int SH_W = 5
) (
  input  logic [W-1:0]    value_i,
  input  logic [SH_W-1:0] shamt_i,
  output logic [W-1:0]    value_o,
  output logic            guard_o,
  output logic            sticky_o
);

  always_comb begin
    value_o  = value_i >> shamt_i;
    guard_o  = 1'b0;
    sticky_o = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i + 1 == int'(shamt_i)) guard_o = value_i[i];
      if (i + 1 < int'(shamt_i))  sticky_o = sticky_o | value_i[i];
    end
  end

endmodule

// File: rtl/float_to_int_nb.sv
// Pipelined IEEE-754 single to signed OUT_W-bit integer converter, latency 3.
// Define FLOAT_TO_INT_RNE_EN for round-to-nearest-even; otherwise truncates toward zero.
module float_to_int_nb
  import float_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      din,
  input  logic             din_valid,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  output logic             dout_ovf
);

  localparam int SH_W  = $clog2(OUT_W + 1);
  localparam int SIG_W = MAN_W + 1;

`ifdef FLOAT_TO_INT_RNE_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  localparam logic [OUT_W:0]   NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W:0]   POS_LIM = NEG_LIM - 1'b1;
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  float_t inOp_q;
  logic   inValid_q;

  logic             s1Valid_q, s1Sign_q, s1Stick_q, s1Stick_d;
  f2i_class_e       s1Class_q, s1Class_d;
  logic [OUT_W-1:0] s1Val_q, s1Val_d;
  logic [SH_W-1:0]  s1Sh_q, s1Sh_d;

  logic             s2Valid_q, s2Sign_q, s2Guard_q, s2Sticky_q;
  f2i_class_e       s2Class_q;
  logic [OUT_W-1:0] s2Mag_q;

  logic [OUT_W-1:0] dout_q, dout_d;
  logic             doutValid_q, doutOvf_q, doutOvf_d;

  logic [SIG_W-1:0] sig;
  logic [OUT_W-1:0] winVal;
  logic             winStick;
  logic [OUT_W-1:0] alignVal;
  logic             alignGuard, alignSticky;
  logic             roundUp;
  logic [OUT_W:0]   rounded;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inOp_q    <= '0;
      inValid_q <= 1'b0;
    end else begin
      inValid_q <= din_valid;
      if (din_valid) inOp_q <= din;
    end
  end

  // The significand window keeps the top OUT_W bits with the hidden one at the MSB,
  // so a shift of OUT_W-1-unbiasedExp leaves the integer part.
  assign sig = {1'b1, inOp_q.man};

  generate
    if (OUT_W > SIG_W) begin : gWinPad
      assign winVal   = {sig, {(OUT_W-SIG_W){1'b0}}};
      assign winStick = 1'b0;
    end else if (OUT_W == SIG_W) begin : gWinExact
      assign winVal   = sig;
      assign winStick = 1'b0;
    end else begin : gWinCut
      assign winVal   = sig[SIG_W-1 -: OUT_W];
      assign winStick = |sig[SIG_W-OUT_W-1:0];
    end
  endgenerate

  always_comb begin
    s1Class_d = CLS_NORM;
    s1Val_d   = winVal;
    s1Stick_d = winStick;
    s1Sh_d    = '0;
    if (isZeroOrDenorm(inOp_q)) begin
      s1Class_d = CLS_ZERO;
    end else if (isNan(inOp_q)) begin
      s1Class_d = CLS_NAN;
    end else if (inOp_q.exp >= EXP_W'(EXP_BIAS + OUT_W)) begin
      s1Class_d = CLS_SAT;
    end else if (inOp_q.exp < EXP_W'(EXP_BIAS - 1)) begin
      s1Val_d   = '0;
      s1Stick_d = 1'b1;
    end else begin
      s1Sh_d = SH_W'(EXP_BIAS + OUT_W - 1 - int'(inOp_q.exp));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Sign_q  <= 1'b0;
      s1Class_q <= CLS_ZERO;
      s1Val_q   <= '0;
      s1Sh_q    <= '0;
      s1Stick_q <= 1'b0;
    end else begin
      s1Valid_q <= inValid_q;
      s1Sign_q  <= inOp_q.sign;
      s1Class_q <= s1Class_d;
      s1Val_q   <= s1Val_d;
      s1Sh_q    <= s1Sh_d;
      s1Stick_q <= s1Stick_d;
    end
  end

  float_rshift_sticky #(
    .W    (OUT_W),
    .SH_W (SH_W)
  ) uAlign (
    .value_i  (s1Val_q),
    .shamt_i  (s1Sh_q),
    .value_o  (alignVal),
    .guard_o  (alignGuard),
    .sticky_o (alignSticky)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_q  <= 1'b0;
      s2Sign_q   <= 1'b0;
      s2Class_q  <= CLS_ZERO;
      s2Mag_q    <= '0;
      s2Guard_q  <= 1'b0;
      s2Sticky_q <= 1'b0;
    end else begin
      s2Valid_q  <= s1Valid_q;
      s2Sign_q   <= s1Sign_q;
      s2Class_q  <= s1Class_q;
      s2Mag_q    <= alignVal;
      s2Guard_q  <= alignGuard;
      s2Sticky_q <= alignSticky | s1Stick_q;
    end
  end

  assign roundUp = RNE_EN & s2Guard_q & (s2Sticky_q | s2Mag_q[0]);
  assign rounded = {1'b0, s2Mag_q} + (OUT_W+1)'(roundUp);

  // Negative side may reach exactly 2^(OUT_W-1) before it counts as overflow.
  always_comb begin
    dout_d    = '0;
    doutOvf_d = 1'b0;
    case (s2Class_q)
      CLS_ZERO: begin
        dout_d = '0;
      end
      CLS_NAN: begin
        doutOvf_d = 1'b1;
      end
      CLS_SAT: begin
        doutOvf_d = 1'b1;
        dout_d    = s2Sign_q ? MIN_NEG : MAX_POS;
      end
      default: begin
        if (!s2Sign_q && (rounded > POS_LIM)) begin
          doutOvf_d = 1'b1;
          dout_d    = MAX_POS;
        end else if (s2Sign_q && (rounded > NEG_LIM)) begin
          doutOvf_d = 1'b1;
          dout_d    = MIN_NEG;
        end else if (s2Sign_q) begin
          dout_d = ~rounded[OUT_W-1:0] + 1'b1;
        end else begin
          dout_d = rounded[OUT_W-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      doutOvf_q   <= 1'b0;
    end else begin
      doutValid_q <= s2Valid_q;
      if (s2Valid_q) begin
        dout_q    <= dout_d;
        doutOvf_q <= doutOvf_d;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = doutValid_q;
  assign dout_ovf   = doutOvf_q;

endmodule

// File: tb/tb_float_to_int_nb.sv
// Directed and randomized checks for float_to_int_nb at OUT_W=16; expectations
// follow FLOAT_TO_INT_RNE_EN when it is defined, truncation otherwise.
module tb_float_to_int_nb;

  localparam int OUT_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ovf;

  int errors = 0;
  int checks = 0;
  logic [15:0] expQ[$];

  always #5 clk = ~clk;

  float_to_int_nb #(.OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ovf   (dout_ovf)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Value q/4 as a single-precision bit pattern (exact for |q| <= 65536).
  function automatic logic [31:0] quarterToFloat(int q);
    int m;
    int p;
    logic [31:0] f;
    m = (q < 0) ? -q : q;
    if (m == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 18; i++) if (m[i]) p = i;
    f[31]    = (q < 0);
    f[30:23] = 8'(127 + p - 2);
    f[22:0]  = 23'(m << (23 - p));
    return f;
  endfunction

  function automatic logic [15:0] modelConv(int q);
    int a;
    int n;
    a = (q < 0) ? -q : q;
    n = a / 4;
`ifdef FLOAT_TO_INT_RNE_EN
    if ((a % 4 > 2) || ((a % 4 == 2) && (n % 2 == 1))) n = n + 1;
`endif
    return (q < 0) ? 16'(-n) : 16'(n);
  endfunction

  task automatic sendOne(input logic [31:0] d, output logic [15:0] o, output logic ov,
                         output int edges);
    @(negedge clk);
    din = d;
    din_valid = 1'b1;
    edges = -1;
    o = '0;
    ov = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) din_valid = 1'b0;
      if (dout_valid) begin
        edges = c - 1;
        o = dout;
        ov = dout_ovf;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dout !== 16'h0) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 0000", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", dout_valid); end
    checks++; if (dout_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", dout_ovf); end
    rst = 1'b0;
  endtask

  task automatic test_latency;
    logic [15:0] o;
    logic ov;
    int edges;
    logic [15:0] expV;
`ifdef FLOAT_TO_INT_RNE_EN
    expV = 16'd2;
`else
    expV = 16'd1;
`endif
    sendOne(32'h3FC00000, o, ov, edges);
    checks++; if (edges != 3) begin errors++; $display("[TB] FAIL latency: got %0d expected 3", edges); end
    checks++; if (o !== expV) begin errors++; $display("[TB] FAIL one_point_five: got %h expected %h", o, expV); end
    checks++; if (ov !== 1'b0) begin errors++; $display("[TB] FAIL one_point_five_ovf: got %b expected 0", ov); end
    @(negedge clk);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_width: got %b expected 0", dout_valid); end
  endtask

  task automatic test_rounding;
    logic [31:0] vin [6];
    logic [15:0] vexp[6];
    logic [15:0] o;
    logic ov;
    int edges;
    vin = '{32'h40200000, 32'hC0600000, 32'h3F000000, 32'h3F400000, 32'h40700000, 32'hC0200000};
`ifdef FLOAT_TO_INT_RNE_EN
    vexp = '{16'h0002, 16'hFFFC, 16'h0000, 16'h0001, 16'h0004, 16'hFFFE};
`else
    vexp = '{16'h0002, 16'hFFFD, 16'h0000, 16'h0000, 16'h0003, 16'hFFFE};
`endif
    for (int i = 0; i < 6; i++) begin
      sendOne(vin[i], o, ov, edges);
      checks++; if (o !== vexp[i]) begin errors++; $display("[TB] FAIL round_%h: got %h expected %h", vin[i], o, vexp[i]); end
      checks++; if (ov !== 1'b0) begin errors++; $display("[TB] FAIL round_ovf_%h: got %b expected 0", vin[i], ov); end
    end
  endtask

  task automatic test_boundaries;
    logic [31:0] vin [10];
    logic [15:0] vexp[10];
    logic        vovf[10];
    logic [15:0] o;
    logic ov;
    int edges;
    vin  = '{32'h47000000, 32'hC7000000, 32'h46FFFE00, 32'h47800000, 32'h7FC00000,
             32'h80000000, 32'h00000001, 32'h3E800000, 32'hFF800000, 32'h7F800000};
    vexp = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000,
             16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF};
    vovf = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      sendOne(vin[i], o, ov, edges);
      checks++; if (o !== vexp[i]) begin errors++; $display("[TB] FAIL bound_%h: got %h expected %h", vin[i], o, vexp[i]); end
      checks++; if (ov !== vovf[i]) begin errors++; $display("[TB] FAIL bound_ovf_%h: got %b expected %b", vin[i], ov, vovf[i]); end
    end
  endtask

  task automatic test_hold;
    repeat (3) @(negedge clk);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_valid: got %b expected 0", dout_valid); end
    checks++; if (dout !== 16'h7FFF) begin errors++; $display("[TB] FAIL hold_dout: got %h expected 7fff", dout); end
    checks++; if (dout_ovf !== 1'b1) begin errors++; $display("[TB] FAIL hold_ovf: got %b expected 1", dout_ovf); end
  endtask

  task automatic test_reset_flush;
    logic [15:0] o;
    logic ov;
    int edges;
    int spurious;
    @(negedge clk);
    din = 32'h40700000;
    din_valid = 1'b1;
    @(negedge clk);
    din = 32'hC0600000;
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (dout !== 16'h0) begin errors++; $display("[TB] FAIL flush_dout_in_reset: got %h expected 0000", dout); end
    checks++; if (dout_ovf !== 1'b0) begin errors++; $display("[TB] FAIL flush_ovf_in_reset: got %b expected 0", dout_ovf); end
    rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (dout_valid) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("[TB] FAIL flush_no_valid: got %0d pulses expected 0", spurious); end
    checks++; if (dout !== 16'h0) begin errors++; $display("[TB] FAIL flush_dout_after: got %h expected 0000", dout); end
    sendOne(32'h40200000, o, ov, edges);
    checks++; if (edges != 3) begin errors++; $display("[TB] FAIL flush_latency: got %0d expected 3", edges); end
    checks++; if (o !== 16'h0002) begin errors++; $display("[TB] FAIL flush_next_dout: got %h expected 0002", o); end
  endtask

  task automatic test_back_to_back;
    int got;
    int gaps;
    bit started;
    logic [15:0] e;
    expQ.delete();
    got = 0;
    gaps = 0;
    started = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          int q;
          @(negedge clk);
          q = int'($urandom_range(0, 131072)) - 65536;
          din = quarterToFloat(q);
          din_valid = 1'b1;
          expQ.push_back(modelConv(q));
        end
        @(negedge clk);
        din_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 1200 && got < 1000; c++) begin
          @(negedge clk);
          if (dout_valid) begin
            started = 1'b1;
            e = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
            checks++;
            if (dout !== e || dout_ovf !== 1'b0) begin
              errors++;
              $display("[TB] FAIL random_%0d: got %h ovf %b expected %h ovf 0", got, dout, dout_ovf, e);
            end
            got++;
          end else if (started) begin
            gaps++;
          end
        end
      end
    join
    checks++; if (got != 1000) begin errors++; $display("[TB] FAIL random_count: got %0d expected 1000", got); end
    checks++; if (gaps != 0) begin errors++; $display("[TB] FAIL random_gaps: got %0d expected 0", gaps); end
  endtask

  initial begin
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    test_reset;
    test_latency;
    test_rounding;
    test_boundaries;
    test_hold;
    test_reset_flush;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/float_to_int_nb.md
FLOAT_TO_INT_NB -- requirements
Module: float_to_int_nb

Interface
REQ-001 SHALL have parameter OUT_W, default 16: width of the signed integer result (range 8..31).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port din, input, 32: IEEE-754 single-precision operand (sign[31], exp[30:23], man[22:0]).
REQ-005 SHALL have port din_valid, input, 1: din is sampled on any edge where din_valid=1; there is no backpressure.
REQ-006 SHALL have port dout, output, OUT_W: signed two's-complement result.
REQ-007 SHALL have port dout_valid, output, 1: single-cycle qualifier for dout.
REQ-008 SHALL have port dout_ovf, output, 1: result saturated or operand NaN; qualified by dout_valid.

Function
REQ-009 SHALL be a 3-stage pipeline: S1 unpack/classify, S2 align (right shift with guard/sticky), S3 round/negate/saturate.
REQ-010 SHALL have a fixed latency of 3: an operand sampled at edge k produces dout_valid=1 after edge k+3, for exactly one cycle.
REQ-011 SHALL accept one operand per cycle; back-to-back valids produce back-to-back results in order.
REQ-012 SHALL propagate a valid bit through each stage; bubbles stay bubbles.
REQ-013 SHALL hold dout and dout_ovf at their last values while dout_valid=0.
REQ-014 SHALL produce 0 with dout_ovf=0 for zero and denormal inputs (exp==0), including -0.
REQ-015 SHALL restore the hidden one for normal inputs (exp 1..254) and form magnitude = 1.man * 2^(exp-127).
REQ-016 SHALL produce 0 before rounding when exp < 126, with sticky=1 if the value is nonzero.
REQ-017 SHALL round per REQ-027 using the guard bit and the OR of all bits below it (sticky).
REQ-018 SHALL apply the sign after rounding.
REQ-019 SHALL saturate results above 2^(OUT_W-1)-1 to 2^(OUT_W-1)-1 and results below -2^(OUT_W-1) to -2^(OUT_W-1), setting dout_ovf=1 in both cases.
REQ-020 SHALL produce exactly -2^(OUT_W-1) with dout_ovf=0 (not overflow).
REQ-021 SHALL saturate +/-Inf by sign with dout_ovf=1.
REQ-022 SHALL produce 0 with dout_ovf=1 for NaN (exp==255, man!=0).
REQ-023 SHALL detect overflow before the S2 shift (exp >= 127+OUT_W), so no internal width exceeds OUT_W+3 bits.

Reset
REQ-024 SHALL force dout=0, dout_valid=0, dout_ovf=0 and clear all stage valid bits while rst=1.
REQ-025 SHALL discard operands in flight when rst asserts mid-operation; none of them produce a dout_valid pulse.
REQ-026 SHALL accept an operand on the first rising edge on which rst=0 (synchronous deassertion is the integrator's responsibility).

Configuration
REQ-027 SHALL select rounding with macro FLOAT_TO_INT_RNE_EN: defined gives round-to-nearest, ties-to-even; undefined gives truncation toward zero (guard/sticky ignored), with latency unchanged.

Structure
REQ-028 SHALL place float_t (packed struct: sign, exp[7:0], man[22:0]), EXP_BIAS=127, EXP_MAX=255 and MAN_W=23 in shared package float_pkg, alongside the float adder's types.
REQ-029 SHALL implement the S2 aligner as sub-module float_rshift_sticky (inputs: value, shift amount; outputs: shifted value, guard, sticky), which is purely combinational.

Verification (OUT_W=16, RNE unless stated)
REQ-030 SHALL check din=0x3FC00000 (1.5) -> dout=2, ovf=0, valid exactly 3 edges after input; without FLOAT_TO_INT_RNE_EN, dout=1.
REQ-031 SHALL check ties: 0x40200000 (2.5) -> 2; 0xC0600000 (-3.5) -> 0xFFFC (-4); 0x3F000000 (0.5) -> 0; 0x3F400000 (0.75) -> 1.
REQ-032 SHALL check boundaries: 0x47000000 (32768.0) -> 0x7FFF with ovf=1; 0xC7000000 (-32768.0) -> 0x8000 with ovf=0; 0x7F800000 (+Inf) -> 0x7FFF with ovf=1; 0x7FC00000 (NaN) -> 0 with ovf=1; 0x80000000 (-0) -> 0 with ovf=0.
REQ-033 SHALL check 1000 random operands in [-16384, 16384] at one per cycle against the shortreal model -> every dout matches, in order, on consecutive cycles.
REQ-034 SHALL check rst asserted for one cycle with two operands in flight -> no dout_valid for those operands, outputs 0, and the next operand after release has latency 3.
